// File: rtl/display7seg_ndigitos.sv
// N-digit binary to active-low seven-segment driver using a one-bit-per-clock double-dabble engine.
// Optional leading-zero blanking is enabled by defining DISPLAY7SEG_BLANK_ZEROS_EN.
module display7seg_ndigitos #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_valor,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_seg
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  function automatic longint unsigned pow10_m1(input int d);
    longint unsigned p;
    p = 64'd1;
    for (int k = 0; k < d; k++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // One spare nibble beyond the input's decimal span keeps the add-3 carries intact.
  localparam int NDEC  = dec_digits(WIDTH) + 1;
  localparam int BCD_N = (DIGITS > NDEC) ? DIGITS : NDEC;
  localparam int BCD_W = 4 * BCD_N;
  localparam logic [63:0] LIMIT    = pow10_m1(DIGITS);
  localparam logic [5:0]  CNT_INIT = 6'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_UPDATE} state_t;

  state_t              r_state, w_state_n;
  logic [WIDTH-1:0]    r_bin, w_bin_n;
  logic [BCD_W-1:0]    r_bcd, w_bcd_n, w_adj;
  logic [5:0]          r_cnt, w_cnt_n;
  logic                r_ovf_next, w_ovf_next_n;
  logic                r_ovf, w_ovf_n;
  logic                r_done, w_done_n;
  logic                r_busy, w_busy_n;
  logic [7*DIGITS-1:0] r_seg, w_seg_n, w_seg_calc;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_N; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_seg_calc = '1;
`ifdef DISPLAY7SEG_BLANK_ZEROS_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
        if (r_bcd[4*i +: 4] != 4'd0 || i == 0) lead = 1'b0;
        w_seg_calc[7*i +: 7] = r_ovf_next ? 7'b0111111 :
                               (lead ? 7'b1111111 : seg7(r_bcd[4*i +: 4]));
      end
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      w_seg_calc[7*i +: 7] = r_ovf_next ? 7'b0111111 : seg7(r_bcd[4*i +: 4]);
    end
`endif
  end

  always_comb begin
    w_state_n    = r_state;
    w_bin_n      = r_bin;
    w_bcd_n      = r_bcd;
    w_cnt_n      = r_cnt;
    w_ovf_next_n = r_ovf_next;
    w_ovf_n      = r_ovf;
    w_seg_n      = r_seg;
    w_done_n     = 1'b0;
    w_busy_n     = r_busy;
    case (r_state)
      S_IDLE: begin
        if (i_load) begin
          w_bin_n      = i_valor;
          w_bcd_n      = '0;
          w_ovf_next_n = (64'(i_valor) > LIMIT);
          w_cnt_n      = CNT_INIT;
          w_busy_n     = 1'b1;
          w_state_n    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {w_bcd_n, w_bin_n} = {w_adj[BCD_W-2:0], r_bin, 1'b0};
        w_cnt_n = r_cnt - 6'd1;
        if (r_cnt == 6'd1) w_state_n = S_UPDATE;
      end
      S_UPDATE: begin
        w_seg_n   = w_seg_calc;
        w_ovf_n   = r_ovf_next;
        w_done_n  = 1'b1;
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_ovf      <= 1'b0;
      r_seg      <= '1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_bin      <= w_bin_n;
      r_bcd      <= w_bcd_n;
      r_cnt      <= w_cnt_n;
      r_ovf_next <= w_ovf_next_n;
      r_ovf      <= w_ovf_n;
      r_seg      <= w_seg_n;
      r_done     <= w_done_n;
      r_busy     <= w_busy_n;
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_ovf;
  assign o_seg      = r_seg;

endmodule
